// File: rtl/demux12_4_stream.sv
// Registered 1-to-2 stream demultiplexer: each input word is routed by s into a
// one-entry buffer on channel 0 or 1, with valid/ready on the input and both outputs.
module demux12_4_stream #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] w,
  input  logic             s,
  input  logic             v_in,
  output logic             r_in,
  output logic [WIDTH-1:0] y0,
  output logic             v0,
  input  logic             r0,
  output logic [WIDTH-1:0] y1,
  output logic             v1,
  input  logic             r1,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} st_t;

  localparam int NUM_CH = 2;

  logic [NUM_CH-1:0]            w_rdy;
  logic [NUM_CH-1:0]            w_v;
  logic [NUM_CH-1:0]            w_ld;
  logic [NUM_CH-1:0][WIDTH-1:0] w_y;
  logic [NUM_CH-1:0][CNT_W-1:0] w_cnt;
  logic                         w_acc;

  assign w_rdy = {r1, r0};

  // Only the selected channel can stall the input; the other never blocks.
  assign r_in  = ~w_v[s] | w_rdy[s];
  assign w_acc = v_in & r_in;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    st_t              r_st;
    logic [WIDTH-1:0] r_y;
    logic [CNT_W-1:0] r_cnt;

    assign w_ld[g]  = w_acc & (s == 1'(g));
    assign w_v[g]   = (r_st == ST_FULL);
    assign w_y[g]   = r_y;
    assign w_cnt[g] = r_cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_st  <= ST_EMPTY;
        r_y   <= '0;
        r_cnt <= '0;
      end else begin
        if (r_st == ST_EMPTY) begin
          if (w_ld[g]) begin
            r_st <= ST_FULL;
            r_y  <= w;
          end
        end else begin
          // A load into a FULL channel implies its ready was high: drain and reload.
          if (w_ld[g])
            r_y <= w;
          else if (w_rdy[g])
            r_st <= ST_EMPTY;
        end
        if (w_v[g] & w_rdy[g])
          r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign y0   = w_y[0];
  assign v0   = w_v[0];
  assign cnt0 = w_cnt[0];
  assign y1   = w_y[1];
  assign v1   = w_v[1];
  assign cnt1 = w_cnt[1];

endmodule
